// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM pipeline register.
//   - default width constants for ex_mem_pipe parameters
//   - NZCV flag bit positions (N=3 .. V=0)
//   - skid-buffer state encoding
//   - entry struct at default widths (ex_mem_pipe re-declares it at its
//     parameterised widths with identical field order)
// Optional feature macro: EX_MEM_FLAGS_EN adds the 4-bit NZCV field.
package ex_mem_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_RADDR_W = 3;
  localparam int unsigned DEF_NWB     = 2;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]          alu;
    logic [DEF_DATA_W-1:0]          addr;
    logic [DEF_DATA_W-1:0]          store;
    logic [DEF_NWB*DEF_RADDR_W-1:0] rd;
    logic [DEF_NWB-1:0]             we;
    logic                           memRd;
    logic                           memWr;
`ifdef EX_MEM_FLAGS_EN
    logic [FLAG_N:FLAG_V]           flags;
`endif
  } entryT;

  function automatic logic [3:0] packNzcv(input logic n, input logic z,
                                          input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: enable-loaded register holding one pipeline entry.
//   clk   - rising-edge clock
//   reset - asynchronous active-low clear
//   load  - capture d on the next rising edge
//   d / q - flattened entry in / out (W bits)
module pipe_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage as a 2-entry skid buffer (main + skid
// register, FIFO order). in_ready depends on the state register only, so
// there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, reset (async active-low), flush (drops all held entries)
//   in_valid/in_ready, out_valid/out_ready : valid/ready handshakes
//   in_alu/in_addr/in_store (DATA_W), in_rd (NWB*RADDR_W), in_we (NWB),
//   in_mem_rd/in_mem_wr and matching out_* presenting the main register
//   in_flags/out_flags (NZCV) only when EX_MEM_FLAGS_EN is defined
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RADDR_W  = DEF_RADDR_W,
  parameter int unsigned NWB      = DEF_NWB,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_alu,
  input  logic [DATA_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_store,
  input  logic [NWB*RADDR_W-1:0] in_rd,
  input  logic [NWB-1:0]         in_we,
  input  logic                   in_mem_rd,
  input  logic                   in_mem_wr,
`ifdef EX_MEM_FLAGS_EN
  input  logic [3:0]             in_flags,
  output logic [3:0]             out_flags,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_alu,
  output logic [DATA_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_store,
  output logic [NWB*RADDR_W-1:0] out_rd,
  output logic [NWB-1:0]         out_we,
  output logic                   out_mem_rd,
  output logic                   out_mem_wr
);

  typedef struct packed {
    logic [DATA_W-1:0]      alu;
    logic [DATA_W-1:0]      addr;
    logic [DATA_W-1:0]      store;
    logic [NWB*RADDR_W-1:0] rd;
    logic [NWB-1:0]         we;
    logic                   memRd;
    logic                   memWr;
`ifdef EX_MEM_FLAGS_EN
    logic [FLAG_N:FLAG_V]   flags;
`endif
  } pipeEntryT;

  stateT     state, stateNext;
  pipeEntryT inEntry, mainD, mainQ, skidQ;
  logic      accept, emit, mainLoad, skidLoad;
  logic [NWB-1:0] weMasked;

  // Write enables to a zero destination are dropped at capture time.
  for (genvar k = 0; k < NWB; k++) begin : gWe
    assign weMasked[k] = in_we[k] & ~(ZERO_REG & (in_rd[k*RADDR_W +: RADDR_W] == '0));
  end

  always_comb begin
    inEntry.alu   = in_alu;
    inEntry.addr  = in_addr;
    inEntry.store = in_store;
    inEntry.rd    = in_rd;
    inEntry.we    = weMasked;
    // A simultaneous read+write strobe is captured as a write.
    inEntry.memRd = in_mem_rd & ~in_mem_wr;
    inEntry.memWr = in_mem_wr;
`ifdef EX_MEM_FLAGS_EN
    inEntry.flags = in_flags;
`endif
  end

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) stateNext = ONE;
        ONE: begin
          if (accept && !emit)      stateNext = TWO;
          else if (!accept && emit) stateNext = EMPTY;
        end
        TWO:     if (emit) stateNext = ONE;
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; end
      ONE:   begin in_ready = 1'b1; out_valid = 1'b1; end
      TWO:   begin in_ready = 1'b0; out_valid = 1'b1; end
      default: begin in_ready = 1'b1; out_valid = 1'b0; end
    endcase
  end

  // Main reloads from the input when it is free or being emitted this cycle,
  // or from the skid when draining TWO. Flush blocks every load so a
  // same-cycle accept is dropped and out data keep the last held entry.
  always_comb begin
    mainLoad = !flush && ((accept && (state == EMPTY || (state == ONE && emit)))
                          || (state == TWO && emit));
    skidLoad = !flush && (state == ONE) && accept && !emit;
    mainD    = (state == TWO) ? skidQ : inEntry;
  end

  pipe_entry_reg #(.W($bits(pipeEntryT))) uMain (
    .clk   (clk),
    .reset (reset),
    .load  (mainLoad),
    .d     (mainD),
    .q     (mainQ)
  );

  pipe_entry_reg #(.W($bits(pipeEntryT))) uSkid (
    .clk   (clk),
    .reset (reset),
    .load  (skidLoad),
    .d     (inEntry),
    .q     (skidQ)
  );

  assign out_alu    = mainQ.alu;
  assign out_addr   = mainQ.addr;
  assign out_store  = mainQ.store;
  assign out_rd     = mainQ.rd;
  assign out_we     = out_valid ? mainQ.we : '0;
  assign out_mem_rd = out_valid & mainQ.memRd;
  assign out_mem_wr = out_valid & mainQ.memWr;
`ifdef EX_MEM_FLAGS_EN
  assign out_flags  = mainQ.flags;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed scenarios plus randomized traffic for ex_mem_pipe,
// checked against a queue-based reference model (ZERO_REG=1, default widths).
module tb_ex_mem_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 3;
  localparam int unsigned NW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_alu = '0, in_addr = '0, in_store = '0;
  logic [NW*RW-1:0] in_rd = '0;
  logic [NW-1:0]   in_we = '0;
  logic            in_mem_rd = 1'b0, in_mem_wr = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_alu, out_addr, out_store;
  logic [NW*RW-1:0] out_rd;
  logic [NW-1:0]   out_we;
  logic            out_mem_rd, out_mem_wr;
`ifdef EX_MEM_FLAGS_EN
  logic [3:0]      in_flags = '0;
  logic [3:0]      out_flags;
`endif

  ex_mem_pipe #(
    .DATA_W   (DW),
    .RADDR_W  (RW),
    .NWB      (NW),
    .ZERO_REG (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu     (in_alu),
    .in_addr    (in_addr),
    .in_store   (in_store),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .in_mem_rd  (in_mem_rd),
    .in_mem_wr  (in_mem_wr),
`ifdef EX_MEM_FLAGS_EN
    .in_flags   (in_flags),
    .out_flags  (out_flags),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu    (out_alu),
    .out_addr   (out_addr),
    .out_store  (out_store),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .out_mem_rd (out_mem_rd),
    .out_mem_wr (out_mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    alu, addr, store;
    logic [NW*RW-1:0] rd;
    logic [NW-1:0]    we;
    logic             mrd, mwr;
    logic [3:0]       flags;
  } itemT;

  itemT q[$];      // entries held, head = the one on the outputs
  itemT held;      // last emitted entry (what out data show when empty)
  bit   heldKnown;
  int   total = 0;
  int   bad = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Entry the pipe should capture from the current inputs.
  function automatic itemT expectOf();
    itemT it;
    logic [NW*RW-1:0] rdv;
    it.alu   = in_alu;
    it.addr  = in_addr;
    it.store = in_store;
    it.rd    = in_rd;
    rdv = in_rd;
    for (int unsigned k = 0; k < NW; k++)
      it.we[k] = in_we[k] && (((rdv >> (k*RW)) & 6'h7) != 0);
    it.mwr = in_mem_wr;
    it.mrd = in_mem_rd && !in_mem_wr;
`ifdef EX_MEM_FLAGS_EN
    it.flags = in_flags;
`else
    it.flags = '0;
`endif
    return it;
  endfunction

  function automatic itemT zeroItem();
    itemT z;
    z.alu = '0; z.addr = '0; z.store = '0; z.rd = '0; z.we = '0;
    z.mrd = 1'b0; z.mwr = 1'b0; z.flags = '0;
    return z;
  endfunction

  task automatic modelReset();
    q.delete();
    held = zeroItem();
    heldKnown = 1'b1;
  endtask

  task automatic modelEdge();
    bit acc, em, wasFull;
    if (!reset) begin
      modelReset();
      return;
    end
    acc = in_valid && (q.size() < 2);
    em  = out_ready && (q.size() > 0);
    wasFull = q.size() > 0;
    if (em) begin
      held = q[0];
      heldKnown = 1'b1;
      void'(q.pop_front());
    end
    if (flush) begin
      if (!em && wasFull) heldKnown = 1'b0;
      q.delete();
    end else if (acc) begin
      q.push_back(expectOf());
    end
  endtask

  task automatic checkOuts();
    checkEq("out_valid", out_valid, q.size() > 0);
    checkEq("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      checkEq("out_alu", out_alu, q[0].alu);
      checkEq("out_addr", out_addr, q[0].addr);
      checkEq("out_store", out_store, q[0].store);
      checkEq("out_rd", out_rd, q[0].rd);
      checkEq("out_we", out_we, q[0].we);
      checkEq("out_mem_rd", out_mem_rd, q[0].mrd);
      checkEq("out_mem_wr", out_mem_wr, q[0].mwr);
`ifdef EX_MEM_FLAGS_EN
      checkEq("out_flags", out_flags, q[0].flags);
`endif
    end else begin
      checkEq("empty_we", out_we, 0);
      checkEq("empty_mem_rd", out_mem_rd, 0);
      checkEq("empty_mem_wr", out_mem_wr, 0);
      if (heldKnown) begin
        checkEq("hold_alu", out_alu, held.alu);
        checkEq("hold_addr", out_addr, held.addr);
        checkEq("hold_store", out_store, held.store);
        checkEq("hold_rd", out_rd, held.rd);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOuts();
  endtask

  task automatic randFields();
    in_alu    = $urandom;
    in_addr   = $urandom;
    in_store  = $urandom;
    in_rd     = NW*RW'($urandom);
    in_we     = NW'($urandom);
    in_mem_rd = 1'($urandom);
    in_mem_wr = 1'($urandom);
`ifdef EX_MEM_FLAGS_EN
    in_flags  = 4'($urandom);
`endif
  endtask

  task automatic push(input logic [DW-1:0] alu);
    randFields();
    in_valid = 1'b1;
    in_alu = alu;
  endtask

  initial begin
    modelReset();
    // Reset asserted: everything zero, ready high.
    #2;
    checkEq("rst_out_valid", out_valid, 0);
    checkEq("rst_in_ready", in_ready, 1);
    checkEq("rst_out_alu", out_alu, 0);
    checkEq("rst_out_we", out_we, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkOuts();
    tick();

    // Back-to-back entries, out_ready high.
    out_ready = 1'b1;
    push(32'h11); tick(); checkEq("b2b_0", out_alu, 32'h11);
    push(32'h22); tick(); checkEq("b2b_1", out_alu, 32'h22);
    push(32'h33); tick(); checkEq("b2b_2", out_alu, 32'h33);
    in_valid = 1'b0; tick();
    checkEq("b2b_drained", out_valid, 0);

    // Fill to TWO with out_ready low, then drain.
    out_ready = 1'b0;
    push(32'hA); tick();
    push(32'hB); tick();
    checkEq("two_in_ready", in_ready, 0);
    checkEq("two_hold_a", out_alu, 32'hA);
    in_valid = 1'b0; tick();
    checkEq("two_still_a", out_alu, 32'hA);
    out_ready = 1'b1; tick();
    checkEq("drain_b", out_alu, 32'hB);
    checkEq("drain_ready", in_ready, 1);
    tick();

    // Flush from TWO with a competing input.
    out_ready = 1'b0;
    push(32'hA); tick();
    push(32'hB); tick();
    push(32'hC); flush = 1'b1; tick();
    checkEq("flush_two_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checkEq("flush_no_c", out_valid, 0);

    // Flush from ONE drops a same-cycle accept.
    out_ready = 1'b0;
    push(32'h1); tick();
    push(32'hC); flush = 1'b1; tick();
    checkEq("flush_one_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();

    // Zero-register write-enable masking and rd/wr collision.
    out_ready = 1'b0;
    push(32'h34); in_rd = {3'd0, 3'd5}; in_we = 2'b11; in_mem_rd = 1'b1; in_mem_wr = 1'b1;
    tick();
    checkEq("zr_we_hi0", out_we, 2'b01);
    checkEq("zr_mem_wr", out_mem_wr, 1);
    checkEq("zr_mem_rd", out_mem_rd, 0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    push(32'h35); in_rd = {3'd5, 3'd0}; in_we = 2'b11; in_mem_rd = 1'b1; in_mem_wr = 1'b1;
    tick();
    checkEq("zr_we_lo0", out_we, 2'b10);
    in_valid = 1'b0; out_ready = 1'b1; tick();

    // Asynchronous reset while in TWO.
    out_ready = 1'b0;
    push(32'h77); tick();
    push(32'h88); tick();
    in_valid = 1'b0;
    checkEq("pre_rst_full", in_ready, 0);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkEq("arst_valid", out_valid, 0);
    checkEq("arst_ready", in_ready, 1);
    checkEq("arst_alu", out_alu, 0);
    checkEq("arst_rd", out_rd, 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    push(32'h55); tick();
    checkEq("post_rst_first", out_alu, 32'h55);
    in_valid = 1'b0; tick();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      randFields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
